mips16_run_ctrl: RTL
====================

# mips16_run_ctrl

Synthesisable run controller beside the `MIPS16` core, replacing fixed delays with parametrised cycle counts and halt detection. It sequences the core's reset, runs the core against a cycle budget and detects halt when the PC stops moving. It also captures a PC/ALU-result trace into a drainable FIFO. It sits between board or bench stimulus and the `MIPS16` `reset`, `pc_out` and `alu_result` pins.

## Interface
- `DATA_W`, 16: width of PC and ALU result.
- `RST_CYCLES`, 5: cycles `core_reset` is held in RESET_HOLD; must be ≥1.
- `MAX_CYCLES`, 250: RUN cycle budget before timeout; must be ≥1.
- `HALT_STABLE`, 4: consecutive unchanged-PC RUN cycles that declare halt; must be ≥1.
- `DEPTH`, 16: trace FIFO entries; power of two, ≥2.
- `CNT_W`, 16: cycle counter width; `MAX_CYCLES` < 2^CNT_W.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low. Low forces all state to reset values immediately.
- `start` in 1: one-cycle request to begin a run; ignored in RESET_HOLD and RUN.
- `pc_in` in DATA_W: core `pc_out`.
- `alu_in` in DATA_W: core `alu_result`.
- `core_reset` out 1: active-high reset to the core.
- `running` out 1: high in RUN.
- `done` out 1: high in DONE.
- `timeout` out 1: sticky cause flag, valid while `done`.
- `halted` out 1: sticky cause flag, valid while `done`.
- `cycle_count` out CNT_W: RUN cycles elapsed in the current or last run.
- `trace_valid` out 1: FIFO head valid.
- `trace_ready` in 1: consumer pops the head when `trace_valid && trace_ready`.
- `trace_pc` out DATA_W: head PC.
- `trace_alu` out DATA_W: head ALU result.
- `trace_overflow` out 1: sticky; set when a push is dropped.

## Operation
- FSM states: IDLE, RESET_HOLD, RUN, DONE.
- IDLE: `core_reset`=1. On `start`, go to RESET_HOLD.
- RESET_HOLD: `core_reset`=1 for exactly RST_CYCLES cycles, then RUN.
- RUN: `core_reset`=0. Increments `cycle_count` each cycle. Compares `pc_in` with the registered previous PC.
- PC changed, or first RUN cycle: push {`pc_in`,`alu_in`} and clear the stable counter.
- PC unchanged: no push; stable counter increments.
- When the stable counter reaches HALT_STABLE: go to DONE and set `halted`.
- When `cycle_count` reaches MAX_CYCLES: go to DONE and set `timeout`.
- If both occur in the same cycle, both flags are set.
- DONE: `core_reset`=1 (core frozen). Flags and `cycle_count` hold. On `start`, go to RESET_HOLD.
- Entering RESET_HOLD from IDLE or DONE clears `cycle_count`, both flags, the stable counter, FIFO contents and `trace_overflow`.
- FIFO full, push with no pop in the same cycle: push dropped, `trace_overflow` set.
- FIFO full, push and pop in the same cycle: both succeed, no overflow.
- FIFO empty: `trace_valid`=0 and `trace_ready` is ignored. A pushed entry is not poppable in the same cycle.
- Draining is allowed in every state. The FIFO is never cleared by DONE.
- Pointers wrap modulo DEPTH. Occupancy counter is log2(DEPTH)+1 bits.

## Timing
- Reset values: `core_reset`=1, `running`=0, `done`=0, `timeout`=0, `halted`=0, `cycle_count`=0, `trace_valid`=0, `trace_pc`=0, `trace_alu`=0, `trace_overflow`=0. State is IDLE.
- `start` at edge N: RESET_HOLD from N+1; RUN from N+1+RST_CYCLES.
- A push at edge N shows `trace_valid`=1 after edge N. Pop is effective at the edge where `trace_valid && trace_ready`.
- With the PC never stable, a run lasts exactly MAX_CYCLES RUN cycles; `done` rises after the final edge with `cycle_count`=MAX_CYCLES.
- `reset` asserted mid-run: immediate return to reset values. No partial trace survives.

## Structure
- Package `mips16_pkg` holds the FSM state enum (IDLE, RESET_HOLD, RUN, DONE) and the default parameter constants.
- Sub-module `mips16_trace_fifo`: synchronous FIFO, width 2*DATA_W, depth DEPTH. Ports: push, pop, full, empty, overflow. The FSM and counters stay in the top.

## Test plan
- `start` with PC incrementing every cycle, MAX_CYCLES=250 → `core_reset` high for 5 cycles; `done`=1, `timeout`=1, `halted`=0, `cycle_count`=250.
- PC 0,2,4, then stuck at 6, HALT_STABLE=4 → `halted`=1 after 4 stuck cycles. Trace drains to 0,2,4,6 with matching ALU values.
- DEPTH=16, `trace_ready`=0, 20 distinct PCs → 16 entries kept (first 16) and `trace_overflow`=1. Then one pop plus push while full → no new overflow.
- Halt and budget expire in the same cycle → `timeout`=1 and `halted`=1.
- `reset` low in the middle of RUN → all outputs return to reset values asynchronously. A second `start` then runs cleanly with counters at 0.
- `start` pulsed during RUN → ignored. `start` in DONE → flags clear and a new RESET_HOLD begins.

Source files
------------

// File: rtl/mips16_pkg.sv
// Shared definitions for the MIPS16 run controller.
//   - Default parameter values for the controller and its trace FIFO.
//   - Run-state encoding (IDLE, RESET_HOLD, RUN, DONE) as fixed 2-bit constants.
package mips16_pkg;

  localparam int unsigned DefDataW      = 16;
  localparam int unsigned DefRstCycles  = 5;
  localparam int unsigned DefMaxCycles  = 250;
  localparam int unsigned DefHaltStable = 4;
  localparam int unsigned DefDepth      = 16;
  localparam int unsigned DefCntW       = 16;

  typedef logic [1:0] run_state_t;

  localparam run_state_t StIdle      = 2'd0;
  localparam run_state_t StResetHold = 2'd1;
  localparam run_state_t StRun       = 2'd2;
  localparam run_state_t StDone      = 2'd3;

endpackage

// File: rtl/mips16_trace_fifo.sv
// Synchronous trace FIFO for the run controller.
// Ports:
//   clk, reset     - clock, asynchronous active-low reset
//   clear          - synchronous flush of contents and the overflow flag
//   push, wdata    - write request and data
//   pop            - read request; ignored while empty
//   rdata          - head entry (zero while empty)
//   full, empty    - occupancy status
//   overflow       - sticky, set when a push is dropped because the FIFO is full
module mips16_trace_fifo
  import mips16_pkg::*;
#(
  parameter int unsigned WIDTH = 2 * DefDataW,
  parameter int unsigned DEPTH = DefDepth
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic             overflow
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             overflow_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == (PtrW + 1)'(DEPTH));

  // A pop frees a slot in the same cycle, so a push into a full FIFO still
  // lands when the head is being consumed.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else if (clear) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + {{PtrW{1'b0}}, do_push} - {{PtrW{1'b0}}, do_pop};
      if (push && !do_push) overflow_q <= 1'b1;
    end
  end

  // Storage needs no reset; the head is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata    = empty ? '0 : mem_q[rd_ptr_q];
  assign overflow = overflow_q;

endmodule

// File: rtl/mips16_run_ctrl.sv
// Run controller for the MIPS16 core: sequences core reset, runs the core
// against a cycle budget, detects halt when the PC stops moving and records
// a PC/ALU trace into a drainable FIFO.
// Ports:
//   clk, reset        - clock, asynchronous active-low reset
//   start             - one-cycle run request (honoured in IDLE and DONE)
//   pc_in, alu_in     - core PC and ALU result
//   core_reset        - active-high reset to the core (low only in RUN)
//   running, done     - state indicators
//   timeout, halted   - sticky cause flags of the last run
//   cycle_count       - RUN cycles elapsed in the current or last run
//   trace_valid/ready - trace FIFO head handshake
//   trace_pc/alu      - trace FIFO head contents
//   trace_overflow    - sticky, a trace push was dropped
module mips16_run_ctrl
  import mips16_pkg::*;
#(
  parameter int unsigned DATA_W      = DefDataW,
  parameter int unsigned RST_CYCLES  = DefRstCycles,
  parameter int unsigned MAX_CYCLES  = DefMaxCycles,
  parameter int unsigned HALT_STABLE = DefHaltStable,
  parameter int unsigned DEPTH       = DefDepth,
  parameter int unsigned CNT_W       = DefCntW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [DATA_W-1:0] alu_in,
  output logic              core_reset,
  output logic              running,
  output logic              done,
  output logic              timeout,
  output logic              halted,
  output logic [CNT_W-1:0]  cycle_count,
  output logic              trace_valid,
  input  logic              trace_ready,
  output logic [DATA_W-1:0] trace_pc,
  output logic [DATA_W-1:0] trace_alu,
  output logic              trace_overflow
);

  localparam int unsigned RstW = $clog2(RST_CYCLES + 1);
  localparam int unsigned StbW = $clog2(HALT_STABLE + 1);

  run_state_t        state_q, state_d;
  logic [RstW-1:0]   rst_cnt_q, rst_cnt_d;
  logic [CNT_W-1:0]  cycle_q, cycle_d;
  logic [StbW-1:0]   stable_q, stable_d;
  logic [DATA_W-1:0] prev_pc_q, prev_pc_d;
  logic              timeout_q, timeout_d;
  logic              halted_q, halted_d;

  logic              pc_moved;
  logic [CNT_W-1:0]  cycle_inc;
  logic [StbW-1:0]   stable_inc;
  logic              trace_push, trace_clear;
  logic              fifo_full, fifo_empty;
  logic [2*DATA_W-1:0] fifo_rdata;

  // cycle_q is zero only in the first RUN cycle, which always records a trace entry.
  assign pc_moved   = (cycle_q == '0) || (pc_in != prev_pc_q);
  assign cycle_inc  = cycle_q + CNT_W'(1);
  assign stable_inc = pc_moved ? '0 : stable_q + StbW'(1);

  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    cycle_d     = cycle_q;
    stable_d    = stable_q;
    prev_pc_d   = prev_pc_q;
    timeout_d   = timeout_q;
    halted_d    = halted_q;
    trace_push  = 1'b0;
    trace_clear = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d     = StResetHold;
          rst_cnt_d   = '0;
          cycle_d     = '0;
          stable_d    = '0;
          timeout_d   = 1'b0;
          halted_d    = 1'b0;
          trace_clear = 1'b1;
        end
      end
      StResetHold: begin
        if (rst_cnt_q == RstW'(RST_CYCLES - 1)) begin
          state_d = StRun;
        end else begin
          rst_cnt_d = rst_cnt_q + RstW'(1);
        end
      end
      StRun: begin
        cycle_d    = cycle_inc;
        prev_pc_d  = pc_in;
        stable_d   = stable_inc;
        trace_push = pc_moved;
        // Both causes can coincide; each flag records its own.
        if (stable_inc == StbW'(HALT_STABLE) || cycle_inc == CNT_W'(MAX_CYCLES)) begin
          state_d   = StDone;
          halted_d  = (stable_inc == StbW'(HALT_STABLE));
          timeout_d = (cycle_inc == CNT_W'(MAX_CYCLES));
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      rst_cnt_q <= '0;
      cycle_q   <= '0;
      stable_q  <= '0;
      prev_pc_q <= '0;
      timeout_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
      cycle_q   <= cycle_d;
      stable_q  <= stable_d;
      prev_pc_q <= prev_pc_d;
      timeout_q <= timeout_d;
      halted_q  <= halted_d;
    end
  end

  mips16_trace_fifo #(
    .WIDTH (2 * DATA_W),
    .DEPTH (DEPTH)
  ) u_trace_fifo (
    .clk      (clk),
    .reset    (reset),
    .clear    (trace_clear),
    .push     (trace_push),
    .wdata    ({pc_in, alu_in}),
    .pop      (trace_ready),
    .rdata    (fifo_rdata),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .overflow (trace_overflow)
  );

  assign core_reset  = (state_q != StRun);
  assign running     = (state_q == StRun);
  assign done        = (state_q == StDone);
  assign timeout     = timeout_q;
  assign halted      = halted_q;
  assign cycle_count = cycle_q;
  assign trace_valid = !fifo_empty;
  assign trace_pc    = fifo_rdata[2*DATA_W-1:DATA_W];
  assign trace_alu   = fifo_rdata[DATA_W-1:0];

endmodule
